// File: rtl/timer_apb_regs_if.sv
// rtl/timer_apb_regs_if.sv - APB bus bundle between a bus master and the timer register block.
interface timer_apb_regs_if #(
  parameter int ADDR_W = 8
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/timer_apb_regs.sv
// rtl/timer_apb_regs.sv - APB slave holding the timer TDR/TCR/TSR registers and exposing TCNT.
// Bus phases are tracked by a four-state FSM; writes commit on the edge that ends ACCESS.
module timer_apb_regs #(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic                  pclk,
  input  logic                  preset,
  timer_apb_regs_if.slave       apb,
  input  logic [7:0]            tcnt,
  input  logic                  ovf_set,
  input  logic                  udf_set,
  output logic [7:0]            tdr,
  output logic [7:0]            tcr,
  output logic                  load
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    WAIT   = 2'd2,
    ACCESS = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [1:0]        wcnt;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        tdr_q;
  logic [6:0]        tcr_q;
  logic [1:0]        tsr_q;
  logic [7:0]        prdata_q;
  logic              load_q;

  logic              addr_ok;
  logic              commit;
  logic              wr_tdr;
  logic              wr_tcr;
  logic              wr_tsr;
  logic [7:0]        rd_val;

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (apb.psel && !apb.penable) state_n = SETUP;
      end
      SETUP: begin
        if (!apb.psel)
          state_n = IDLE;
        else if (apb.penable)
          state_n = (WAIT_STATES == 0) ? ACCESS : WAIT;
      end
      WAIT: begin
        if (!apb.psel)
          state_n = IDLE;
        else if (wcnt == 2'(WAIT_STATES - 1))
          state_n = ACCESS;
      end
      ACCESS: begin
        state_n = (apb.psel && !apb.penable) ? SETUP : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Only addresses 0x00..0x03 decode; anything with upper bits set is an error.
  assign addr_ok = (addr_q[ADDR_W-1:2] == '0);
  assign commit  = (state == ACCESS) && wr_q && addr_ok;
  assign wr_tdr  = commit && (addr_q[1:0] == 2'd0);
  assign wr_tcr  = commit && (addr_q[1:0] == 2'd1);
  assign wr_tsr  = commit && (addr_q[1:0] == 2'd2);

  always_comb begin
    rd_val = 8'h00;
    if (addr_ok) begin
      case (addr_q[1:0])
        2'd0:    rd_val = tdr_q;
        2'd1:    rd_val = {1'b0, tcr_q};
        2'd2:    rd_val = {6'b0, tsr_q};
        default: rd_val = tcnt;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state    <= IDLE;
      wcnt     <= 2'd0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= 8'h00;
      tdr_q    <= 8'h00;
      tcr_q    <= 7'h00;
      tsr_q    <= 2'b00;
      prdata_q <= 8'h00;
      load_q   <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= (state == WAIT) ? wcnt + 2'd1 : 2'd0;
      // Address phase is latched whenever the FSM (re)enters SETUP.
      if (state_n == SETUP) begin
        addr_q  <= apb.paddr;
        wr_q    <= apb.pwrite;
        wdata_q <= apb.pwdata;
      end
      prdata_q <= (state_n == ACCESS) ? rd_val : 8'h00;
      load_q   <= wr_tcr && wdata_q[7];
      if (wr_tdr) tdr_q <= wdata_q;
      if (wr_tcr) tcr_q <= wdata_q[6:0];
      // Set inputs are OR-ed in after the clear so a coincident event wins.
      tsr_q <= (tsr_q & ~(wr_tsr ? wdata_q[1:0] : 2'b00)) | {udf_set, ovf_set};
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pready  = (state == ACCESS);
  assign apb.pslverr = (state == ACCESS) && !addr_ok;
  assign tdr         = tdr_q;
  assign tcr         = {1'b0, tcr_q};
  assign load        = load_q;

endmodule

// File: tb/tb_timer_apb_regs.sv
// tb/tb_timer_apb_regs.sv - directed/random bench for timer_apb_regs against a register-map model.
module tb_timer_apb_regs;

  localparam int WS = 1;

  logic       pclk = 1'b0;
  logic       preset;
  logic [7:0] tcnt;
  logic       ovf_set;
  logic       udf_set;
  logic [7:0] tdr;
  logic [7:0] tcr;
  logic       load;

  timer_apb_regs_if #(.ADDR_W(8)) bus ();

  timer_apb_regs #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
    .pclk    (pclk),
    .preset  (preset),
    .apb     (bus),
    .tcnt    (tcnt),
    .ovf_set (ovf_set),
    .udf_set (udf_set),
    .tdr     (tdr),
    .tcr     (tcr),
    .load    (load)
  );

  always #5 pclk = ~pclk;

  int total = 0;
  int bad   = 0;

  // Register-map model
  logic [7:0] m_tdr;
  logic [6:0] m_tcr;
  logic [1:0] m_tsr;

  logic [7:0] rd;
  logic       err;
  logic       ld;
  logic [7:0] d;
  logic [7:0] prior;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [7:0] a);
    if (a > 8'd3) return 8'h00;
    case (a[1:0])
      2'd0:    return m_tdr;
      2'd1:    return {1'b0, m_tcr};
      2'd2:    return {6'b0, m_tsr};
      default: return tcnt;
    endcase
  endfunction

  task automatic model_reset();
    m_tdr = 8'h00;
    m_tcr = 7'h00;
    m_tsr = 2'b00;
  endtask

  // One complete transfer; setm pulses ovf/udf in the ACCESS cycle.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [7:0] dv, input logic [1:0] setm,
                      output logic [7:0] rdv, output logic errv, output logic ldv);
    int low;
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = w; bus.paddr = a; bus.pwdata = dv;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    low = 0;
    while (bus.pready !== 1'b1 && low < 40) begin
      low++;
      @(posedge pclk); #1;
    end
    chk("wait_cycles", low, WS + 1);
    rdv = bus.prdata;
    errv = bus.pslverr;
    ovf_set = setm[0];
    udf_set = setm[1];
    @(posedge pclk); #1;
    ovf_set = 1'b0; udf_set = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    chk("pready_one_cycle", bus.pready, 1'b0);
    ldv = load;
    @(posedge pclk); #1;
    chk("load_width", load, 1'b0);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] dv, input logic [1:0] setm);
    xfer(1'b1, a, dv, setm, rd, err, ld);
    chk("wr_pslverr", err, a > 8'd3);
    chk("wr_load", ld, (a == 8'd1) && dv[7]);
    if (a == 8'd0) m_tdr = dv;
    if (a == 8'd1) m_tcr = dv[6:0];
    m_tsr = (m_tsr & ~((a == 8'd2) ? dv[1:0] : 2'b00)) | setm;
    chk("tdr_out", tdr, m_tdr);
    chk("tcr_out", tcr, {1'b0, m_tcr});
  endtask

  task automatic do_read(input logic [7:0] a);
    xfer(1'b0, a, 8'h00, 2'b00, rd, err, ld);
    chk("rd_data", rd, exp_rd(a));
    chk("rd_pslverr", err, a > 8'd3);
    chk("rd_load", ld, 1'b0);
  endtask

  task automatic pulse_ovf();
    @(posedge pclk); #1; ovf_set = 1'b1;
    @(posedge pclk); #1; ovf_set = 1'b0;
    m_tsr[0] = 1'b1;
  endtask

  // Starts a transfer and abandons it in WAIT, either by dropping psel or by reset.
  task automatic abort_xfer(input bit use_reset, input logic [7:0] a, input logic [7:0] dv);
    logic seen;
    seen = 1'b0;
    @(posedge pclk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = dv;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    seen = seen | bus.pready;
    @(posedge pclk); #1;
    seen = seen | bus.pready;
    if (use_reset) preset = 1'b1;
    else begin bus.psel = 1'b0; bus.penable = 1'b0; end
    @(posedge pclk); #1;
    preset = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0;
    seen = seen | bus.pready;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      seen = seen | bus.pready;
    end
    chk("abort_no_pready", seen, 1'b0);
    if (use_reset) model_reset();
  endtask

  initial begin
    preset = 1'b1;
    ovf_set = 1'b1;
    udf_set = 1'b1;
    tcnt = 8'($urandom);
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 8'h00; bus.pwdata = 8'h00;
    model_reset();
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_pready", bus.pready, 1'b0);
    chk("rst_pslverr", bus.pslverr, 1'b0);
    chk("rst_prdata", bus.prdata, 8'h00);
    chk("rst_tdr", tdr, 8'h00);
    chk("rst_tcr", tcr, 8'h00);
    chk("rst_load", load, 1'b0);
    preset = 1'b0; ovf_set = 1'b0; udf_set = 1'b0;

    // Events during reset are discarded
    do_read(8'h02);

    // penable without a setup phase is ignored
    bus.psel = 1'b1; bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = 8'h00; bus.pwdata = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge pclk); #1;
      chk("penable_no_setup", bus.pready, 1'b0);
    end
    bus.psel = 1'b0; bus.penable = 1'b0;
    do_read(8'h00);

    // Random TDR write/read pairs
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      do_write(8'h00, d, 2'b00);
      do_read(8'h00);
    end

    // TCR and load pulse
    do_write(8'h01, 8'h85, 2'b00);
    chk("tcr_is_05", tcr, 8'h05);
    do_read(8'h01);
    do_write(8'h01, 8'h03, 2'b00);
    do_read(8'h01);

    // TSR set / W1C interaction
    pulse_ovf();
    do_read(8'h02);
    do_write(8'h02, 8'h01, 2'b10);
    do_read(8'h02);
    do_write(8'h02, 8'h02, 2'b00);
    do_read(8'h02);
    pulse_ovf();
    do_write(8'h02, 8'h01, 2'b01);
    do_read(8'h02);
    do_write(8'h02, 8'h03, 2'b00);
    do_read(8'h02);

    // Out-of-range addresses and read-only TCNT
    do_write(8'h00, 8'h5A, 2'b00);
    pulse_ovf();
    do_read(8'h07);
    do_write(8'h07, 8'h55, 2'b00);
    do_read(8'h00);
    do_read(8'h01);
    do_read(8'h02);
    do_write(8'h03, 8'h55, 2'b00);
    do_read(8'h03);
    tcnt = 8'($urandom);
    do_read(8'h03);

    // psel dropped in WAIT: TDR keeps its prior value
    prior = 8'($urandom);
    do_write(8'h00, prior, 2'b00);
    abort_xfer(1'b0, 8'h00, 8'h3C);
    chk("tdr_after_drop", tdr, prior);
    do_read(8'h00);

    // Reset in WAIT: no commit, registers cleared
    abort_xfer(1'b1, 8'h00, 8'hAA);
    chk("tdr_after_reset", tdr, 8'h00);
    chk("tcr_after_reset", tcr, 8'h00);
    do_read(8'h00);
    do_read(8'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_apb_regs.md
TIMER_APB_REGS -- requirements
Module: timer_apb_regs

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning APB address width.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, meaning PREADY-low cycles inserted per access (0..3).
REQ-003 The block SHALL have port pclk  input  1  meaning the single clock; all logic on rising edge.
REQ-004 The block SHALL have port preset  input  1  meaning reset, synchronous and active-high.
REQ-005 The block SHALL have port psel  input  1  meaning APB select.
REQ-006 The block SHALL have port penable  input  1  meaning APB access phase.
REQ-007 The block SHALL have port pwrite  input  1  meaning 1 = write, 0 = read.
REQ-008 The block SHALL have port paddr  input  ADDR_W  meaning register address.
REQ-009 The block SHALL have port pwdata  input  8  meaning write data.
REQ-010 The block SHALL have port prdata  output  8  meaning read data, valid when pready=1.
REQ-011 The block SHALL have port pready  output  1  meaning transfer completes this cycle.
REQ-012 The block SHALL have port pslverr  output  1  meaning error response, valid when pready=1.
REQ-013 The block SHALL have port tcnt  input  8  meaning live counter value from the timer core.
REQ-014 The block SHALL have port ovf_set  input  1  meaning one-cycle overflow event.
REQ-015 The block SHALL have port udf_set  input  1  meaning one-cycle underflow event.
REQ-016 The block SHALL have port tdr  output  8  meaning TDR contents to the core.
REQ-017 The block SHALL have port tcr  output  8  meaning TCR contents to the core (bit7 always 0).
REQ-018 The block SHALL have port load  output  1  meaning one-cycle pulse to load TDR into the counter.

Function
REQ-019 Register map SHALL be: 0x00 TDR RW; 0x01 TCR RW; 0x02 TSR (bit0 OVF, bit1 UDF, W1C, other bits read 0); 0x03 TCNT RO.
REQ-020 FSM SHALL have states IDLE, SETUP, WAIT, ACCESS: IDLE->SETUP on psel&!penable; SETUP->WAIT on psel&penable (WAIT_STATES>0) or ->ACCESS (WAIT_STATES=0); WAIT counts WAIT_STATES cycles then ->ACCESS; ACCESS->SETUP if psel&!penable else ->IDLE.
REQ-021 pready SHALL be 1 only in ACCESS; 0 in IDLE, SETUP, WAIT.
REQ-022 Writes SHALL commit on the clock edge ending the ACCESS cycle; the written value reads back from the next transfer.
REQ-023 prdata SHALL be registered, holding the addressed register value during ACCESS, and 0x00 otherwise.
REQ-024 Writing TCR SHALL store bits[6:0]; bit7 written 1 SHALL produce load=1 for exactly one cycle after commit; TCR bit7 SHALL always read 0.
REQ-025 TSR bit SHALL set on its *_set input; write of 1 clears it; simultaneous set and W1C in the same cycle SHALL leave the bit set.
REQ-026 Writes to TCNT SHALL be ignored without error; reads SHALL return tcnt sampled in the ACCESS cycle.
REQ-027 Address >= 0x04 SHALL give pslverr=1 in ACCESS, prdata=0x00, and no register change; pslverr SHALL be 0 otherwise.
REQ-028 If psel deasserts during SETUP or WAIT, FSM SHALL return to IDLE with no commit and no pready.
REQ-029 penable seen without a prior SETUP SHALL be ignored (FSM stays IDLE).
REQ-030 Back-to-back transfers SHALL be supported with no idle cycle between ACCESS and the next SETUP.

Reset
REQ-031 On preset=1 at a clock edge: FSM=IDLE, TDR=0x00, TCR=0x00, TSR=0x00, prdata=0x00, pready=0, pslverr=0, load=0.
REQ-032 Reset SHALL override an in-flight transfer, including ACCESS; no commit occurs on that edge.
REQ-033 ovf_set/udf_set asserted while preset=1 SHALL be discarded.

Verification
REQ-034 20 random writes/reads to 0x00 (e.g. 0x24, 0x81, 0x09) -> each read equals written byte, pslverr=0, pready high for exactly 1 cycle after WAIT_STATES wait cycles.
REQ-035 Write 0x85 to 0x01 -> load=1 for one cycle, tcr=0x05, read of 0x01 returns 0x05.
REQ-036 Pulse ovf_set, read 0x02 -> 0x01; write 0x01 to 0x02 in same cycle as udf_set -> read returns 0x02; write 0x02 -> 0x00.
REQ-037 Read/write 0x07 -> pslverr=1, prdata=0x00, all registers unchanged; write 0x55 to 0x03 -> pslverr=0, read returns tcnt.
REQ-038 Write 0xAA to TDR, assert preset during WAIT -> pready never asserts, read of 0x00 returns 0x00.
REQ-039 Drop psel during WAIT on a TDR write of 0x3C -> TDR keeps its prior value, FSM returns to IDLE.
